psum_acc_buffer: RTL and testbench

//  Partial-sum store directly downstream of the PE engine. Accepts PE psum writes.

---
 rtl/psum_acc_buffer.sv | 200 ++++++++++++++++++++
 tb/tb_psum_acc_buffer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_acc_buffer.sv
// Partial-sum buffer between the PE engine and the output writer: PE read-back/accumulate
// path with a 2-cycle read latency, plus a drain engine that requantises every entry onto a stream.
module psum_acc_buffer #(
  parameter int unsigned W_PSUM     = 32,
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned W_OUT      = 8,
  parameter int unsigned W_SHIFT    = 5,
  parameter int unsigned RELU_EN    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req_psum,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  input  logic                  i_first_tile,
  output logic [W_PSUM-1:0]     o_psum_data,
  output logic                  o_psum_vld,
  input  logic                  i_psum_we,
  input  logic [ADDR_WIDTH-1:0] i_psum_addr,
  input  logic [W_PSUM-1:0]     i_psum_wdata,
  input  logic                  i_drain_start,
  input  logic [ADDR_WIDTH:0]   i_drain_len,
  input  logic [W_SHIFT-1:0]    i_shift,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [W_OUT-1:0]      o_out_data,
  output logic                  o_out_last,
  output logic                  o_busy,
  output logic                  o_drain_done,
  output logic                  o_err
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned W_LEN = ADDR_WIDTH + 1;
  localparam int unsigned W_EXT = W_PSUM + 1;
  localparam logic signed [W_EXT-1:0] SAT_MAX = W_EXT'((1 << (W_OUT - 1)) - 1);
  localparam logic signed [W_EXT-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [W_LEN-1:0]    len_q, len_d;
  logic [W_SHIFT-1:0]  shift_q, shift_d;
  logic [W_LEN-1:0]    rd_cnt_q, rd_cnt_d;
  logic                inflight_q, inflight_d;
  logic                infl_last_q, infl_last_d;
  logic                rd_req_q, rd_req_d;
  logic                rd_first_q, rd_first_d;
  logic                psum_vld_q, psum_vld_d;
  logic [W_PSUM-1:0]   psum_data_q, psum_data_d;
  logic [W_OUT-1:0]    fifo_data_q [2];
  logic [W_OUT-1:0]    fifo_data_d [2];
  logic [1:0]          fifo_last_q, fifo_last_d;
  logic                wr_ptr_q, wr_ptr_d;
  logic                rd_ptr_q, rd_ptr_d;
  logic [1:0]          fifo_cnt_q, fifo_cnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic [W_PSUM-1:0]     psum_mem [DEPTH];
  logic [W_PSUM-1:0]     ram_rdata_q;
  logic                  in_drain_c, pe_rd_c, pe_wr_c, pop_c, issue_c, ram_re_c;
  logic [ADDR_WIDTH-1:0] ram_raddr_c;
  logic [2:0]            occ_c;
  logic signed [W_EXT-1:0] acc_ext_c, rnd_c, rq_c;
  logic [W_OUT-1:0]      requant_c;

  // Arbitration: PE traffic is shut out while draining, so the RAM needs one read port.
  always_comb begin
    in_drain_c  = (state_q == S_DRAIN);
    pe_rd_c     = i_req_psum & ~in_drain_c;
    pe_wr_c     = i_psum_we & ~in_drain_c;
    pop_c       = o_out_valid & i_out_ready;
    // Occupancy after this cycle's pop keeps the stream at one beat per cycle without overflow.
    occ_c       = 3'(fifo_cnt_q) - 3'(pop_c) + 3'(inflight_q);
    issue_c     = in_drain_c && (rd_cnt_q < len_q) && (occ_c < 3'd2);
    ram_re_c    = issue_c | (pe_rd_c & ~i_first_tile);
    ram_raddr_c = in_drain_c ? rd_cnt_q[ADDR_WIDTH-1:0] : i_rd_addr;
  end

  // Read-before-write RAM: a same-address read and write in one cycle returns the old word.
  always_ff @(posedge clk) begin
    if (pe_wr_c) psum_mem[i_psum_addr] <= i_psum_wdata;
    if (ram_re_c) ram_rdata_q <= psum_mem[ram_raddr_c];
  end

  // Requantise: round-half-up shift in W_PSUM+1 bits, optional ReLU, then saturate.
  always_comb begin
    acc_ext_c = signed'({ram_rdata_q[W_PSUM-1], ram_rdata_q});
    rnd_c     = '0;
    if (shift_q != '0) rnd_c = W_EXT'(1) << (shift_q - W_SHIFT'(1));
    rq_c      = (acc_ext_c + rnd_c) >>> shift_q;
    if ((RELU_EN != 0) && rq_c[W_EXT-1]) rq_c = '0;
    if (rq_c > SAT_MAX) rq_c = SAT_MAX;
    else if (rq_c < SAT_MIN) rq_c = SAT_MIN;
    requant_c = W_OUT'(rq_c);
  end

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    shift_d     = shift_q;
    rd_cnt_d    = rd_cnt_q;
    inflight_d  = issue_c;
    infl_last_d = issue_c && (rd_cnt_q == len_q - W_LEN'(1));
    fifo_data_d = fifo_data_q;
    fifo_last_d = fifo_last_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    fifo_cnt_d  = fifo_cnt_q + 2'(inflight_q) - 2'(pop_c);
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_drain_start) begin
          if (i_drain_len != '0) begin
            state_d  = S_DRAIN;
            len_d    = i_drain_len;
            shift_d  = i_shift;
            rd_cnt_d = '0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_DRAIN: if (pop_c && o_out_last) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (issue_c) rd_cnt_d = rd_cnt_q + W_LEN'(1);
    if (inflight_q) begin
      fifo_data_d[wr_ptr_q] = requant_c;
      fifo_last_d[wr_ptr_q] = infl_last_q;
      wr_ptr_d              = ~wr_ptr_q;
    end
    if (pop_c) rd_ptr_d = ~rd_ptr_q;

    rd_req_d    = pe_rd_c;
    rd_first_d  = i_first_tile;
    psum_vld_d  = rd_req_q;
    psum_data_d = (rd_req_q && !rd_first_q) ? ram_rdata_q : '0;

    busy_d = (state_d != S_IDLE);
    done_d = done_d | (state_d == S_DONE);
    err_d  = err_q | (in_drain_c & (i_psum_we | i_req_psum));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      shift_q     <= '0;
      rd_cnt_q    <= '0;
      inflight_q  <= 1'b0;
      infl_last_q <= 1'b0;
      rd_req_q    <= 1'b0;
      rd_first_q  <= 1'b0;
      psum_vld_q  <= 1'b0;
      psum_data_q <= '0;
      fifo_data_q <= '{default: '0};
      fifo_last_q <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      fifo_cnt_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      shift_q     <= shift_d;
      rd_cnt_q    <= rd_cnt_d;
      inflight_q  <= inflight_d;
      infl_last_q <= infl_last_d;
      rd_req_q    <= rd_req_d;
      rd_first_q  <= rd_first_d;
      psum_vld_q  <= psum_vld_d;
      psum_data_q <= psum_data_d;
      fifo_data_q <= fifo_data_d;
      fifo_last_q <= fifo_last_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fifo_cnt_q  <= fifo_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign o_psum_data  = psum_data_q;
  assign o_psum_vld   = psum_vld_q;
  assign o_out_valid  = (fifo_cnt_q != 2'd0);
  assign o_out_data   = fifo_data_q[rd_ptr_q];
  assign o_out_last   = o_out_valid & fifo_last_q[rd_ptr_q];
  assign o_busy       = busy_q;
  assign o_drain_done = done_q;
  assign o_err        = err_q;

endmodule

// File: tb/tb_psum_acc_buffer.sv
// Directed bench for psum_acc_buffer: read-path vector table, RMW, drain with and without
// backpressure, saturation/ReLU corners, zero-length drain, reset abort and drain-time error.
module tb_psum_acc_buffer;

  localparam int unsigned AW = 12;
  localparam int unsigned WP = 32;
  localparam int unsigned WO = 8;
  localparam int unsigned WS = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req_psum, i_first_tile, i_psum_we, i_drain_start, i_out_ready;
  logic [AW-1:0] i_rd_addr, i_psum_addr;
  logic [WP-1:0] i_psum_wdata;
  logic [AW:0]   i_drain_len;
  logic [WS-1:0] i_shift;

  logic [WP-1:0] o_psum_data, nr_psum_data;
  logic          o_psum_vld, nr_psum_vld;
  logic          o_out_valid, nr_out_valid;
  logic [WO-1:0] o_out_data, nr_out_data;
  logic          o_out_last, nr_out_last;
  logic          o_busy, nr_busy, o_drain_done, nr_drain_done, o_err, nr_err;

  int errors = 0;
  int checks = 0;
  longint exp_out [8];

  always #5 clk = ~clk;

  psum_acc_buffer dut (
    .clk(clk), .rst(rst), .i_req_psum(i_req_psum), .i_rd_addr(i_rd_addr),
    .i_first_tile(i_first_tile), .o_psum_data(o_psum_data), .o_psum_vld(o_psum_vld),
    .i_psum_we(i_psum_we), .i_psum_addr(i_psum_addr), .i_psum_wdata(i_psum_wdata),
    .i_drain_start(i_drain_start), .i_drain_len(i_drain_len), .i_shift(i_shift),
    .o_out_valid(o_out_valid), .i_out_ready(i_out_ready), .o_out_data(o_out_data),
    .o_out_last(o_out_last), .o_busy(o_busy), .o_drain_done(o_drain_done), .o_err(o_err)
  );

  // Second instance with ReLU disabled, fed identical stimulus.
  psum_acc_buffer #(.RELU_EN(0)) dut_nr (
    .clk(clk), .rst(rst), .i_req_psum(i_req_psum), .i_rd_addr(i_rd_addr),
    .i_first_tile(i_first_tile), .o_psum_data(nr_psum_data), .o_psum_vld(nr_psum_vld),
    .i_psum_we(i_psum_we), .i_psum_addr(i_psum_addr), .i_psum_wdata(i_psum_wdata),
    .i_drain_start(i_drain_start), .i_drain_len(i_drain_len), .i_shift(i_shift),
    .o_out_valid(nr_out_valid), .i_out_ready(i_out_ready), .o_out_data(nr_out_data),
    .o_out_last(nr_out_last), .o_busy(nr_busy), .o_drain_done(nr_drain_done), .o_err(nr_err)
  );

  typedef struct {
    int     addr;
    logic   first;
    longint exp;
  } rd_vec_t;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input longint v);
    i_psum_we    = 1'b1;
    i_psum_addr  = AW'(a);
    i_psum_wdata = WP'(v);
    tick();
    i_psum_we = 1'b0;
  endtask

  task automatic rd(input int a, input logic first, output longint data);
    i_req_psum   = 1'b1;
    i_rd_addr    = AW'(a);
    i_first_tile = first;
    tick();
    i_req_psum = 1'b0;
    chk("rd_vld_t1", longint'(o_psum_vld), 0);
    tick();
    chk("rd_vld_t2", longint'(o_psum_vld), 1);
    data = longint'($signed(o_psum_data));
  endtask

  task automatic drain_run(input int len, input int sh, input logic [63:0] pat,
                           input bit consec, input bit use_nr);
    int beats, last_cyc, prev_cyc;
    bit stalled, done_seen;
    logic [WO-1:0] d, prev_d;
    logic v, l;
    i_drain_len   = (AW+1)'(len);
    i_shift       = WS'(sh);
    i_out_ready   = pat[0];
    i_drain_start = 1'b1;
    tick();
    i_drain_start = 1'b0;
    chk("drain_busy", longint'(o_busy), 1);
    beats = 0; last_cyc = -10; prev_cyc = -10; stalled = 0; done_seen = 0; prev_d = '0;
    for (int cyc = 1; cyc < 200 && !done_seen; cyc++) begin
      i_out_ready = pat[cyc % 64];
      v = use_nr ? nr_out_valid : o_out_valid;
      d = use_nr ? nr_out_data : o_out_data;
      l = use_nr ? nr_out_last : o_out_last;
      if (stalled) begin
        chk("stall_valid", longint'(v), 1);
        chk("stall_data", longint'($signed(d)), longint'($signed(prev_d)));
      end
      if (v && i_out_ready) begin
        if (beats < len) begin
          chk("beat_data", longint'($signed(d)), exp_out[beats]);
          chk("beat_last", longint'(l), longint'(beats == len - 1));
        end else begin
          chk("extra_beat", longint'(beats), longint'(len));
        end
        if (consec && beats > 0) chk("beat_consec", longint'(cyc), longint'(prev_cyc + 1));
        prev_cyc = cyc;
        beats++;
        if (l) last_cyc = cyc;
      end
      if (o_drain_done) begin
        done_seen = 1;
        chk("done_timing", longint'(cyc), longint'(last_cyc + 1));
      end
      stalled = v && !i_out_ready;
      prev_d  = d;
      tick();
    end
    chk("beat_count", longint'(beats), longint'(len));
    chk("done_seen", longint'(done_seen), 1);
    chk("done_width", longint'(o_drain_done), 0);
    chk("idle_after", longint'(o_busy), 0);
    i_out_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rd_vec_t rtab [7];
    longint  rv;
    logic [63:0] all1, p4;
    int beats;
    bit done_any;

    rtab[0] = '{5,    1'b0, 100};
    rtab[1] = '{5,    1'b1, 0};
    rtab[2] = '{3,    1'b0, -7};
    rtab[3] = '{4095, 1'b0, 2147483647};
    rtab[4] = '{0,    1'b0, -1};
    rtab[5] = '{0,    1'b1, 0};
    rtab[6] = '{3,    1'b0, -7};

    all1 = '1;
    for (int c = 0; c < 64; c++) p4[c] = (c >= 4 && c <= 8) ? 1'b0 : ((c % 2) == 0);

    rst = 1'b1;
    i_req_psum = 0; i_first_tile = 0; i_psum_we = 0; i_drain_start = 0; i_out_ready = 0;
    i_rd_addr = '0; i_psum_addr = '0; i_psum_wdata = '0; i_drain_len = '0; i_shift = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_psum_vld", longint'(o_psum_vld), 0);
    chk("rst_psum_data", longint'(o_psum_data), 0);
    chk("rst_out_valid", longint'(o_out_valid), 0);
    chk("rst_busy", longint'(o_busy), 0);
    chk("rst_done", longint'(o_drain_done), 0);
    chk("rst_err", longint'(o_err), 0);
    rst = 1'b0;
    tick();

    // Read path: back-to-back requests from a vector table, 2-cycle latency
    wr(5, 100); wr(3, -7); wr(4095, 2147483647); wr(0, -1);
    for (int i = 0; i < 9; i++) begin
      if (i < 7) begin
        i_req_psum = 1'b1; i_rd_addr = AW'(rtab[i].addr); i_first_tile = rtab[i].first;
      end else begin
        i_req_psum = 1'b0; i_first_tile = 1'b0;
      end
      tick();
      if (i >= 1 && i - 1 < 7) begin
        chk("tab_vld", longint'(o_psum_vld), 1);
        chk("tab_data", longint'($signed(o_psum_data)), rtab[i-1].exp);
      end
    end
    tick();
    chk("tab_vld_idle", longint'(o_psum_vld), 0);

    // Read-modify-write accumulation: -7 + 10 = 3
    rd(3, 1'b0, rv);
    chk("rmw_read0", rv, -7);
    wr(3, rv + 10);
    tick();
    rd(3, 1'b0, rv);
    chk("rmw_read1", rv, 3);

    // Same-cycle read and write of one address returns the old word
    wr(7, 11);
    i_psum_we = 1'b1; i_psum_addr = AW'(7); i_psum_wdata = WP'(22);
    i_req_psum = 1'b1; i_rd_addr = AW'(7); i_first_tile = 1'b0;
    tick();
    i_psum_we = 1'b0; i_req_psum = 1'b0;
    tick();
    chk("rw_old_data", longint'($signed(o_psum_data)), 11);
    rd(7, 1'b0, rv);
    chk("rw_new_data", rv, 22);

    // Drain, ready held high
    wr(0, 1000); wr(1, -1000); wr(2, 300); wr(3, -5);
    exp_out[0] = 125; exp_out[1] = 0; exp_out[2] = 38; exp_out[3] = 0;
    drain_run(4, 3, all1, 1'b1, 1'b0);

    // Same drain under toggling and held backpressure
    drain_run(4, 3, p4, 1'b0, 1'b0);

    // Saturation with shift 0, with and without ReLU
    wr(0, 70000); wr(1, -70000);
    exp_out[0] = 127; exp_out[1] = 0;
    drain_run(2, 0, all1, 1'b1, 1'b0);
    exp_out[0] = 127; exp_out[1] = -128;
    drain_run(2, 0, all1, 1'b1, 1'b1);

    // Zero-length drain completes immediately
    i_drain_len = '0; i_drain_start = 1'b1;
    tick();
    i_drain_start = 1'b0;
    chk("len0_done", longint'(o_drain_done), 1);
    chk("len0_busy", longint'(o_busy), 0);
    tick();
    chk("len0_done_off", longint'(o_drain_done), 0);

    // Reset after two accepted beats aborts the drain
    wr(0, 1000); wr(1, -1000); wr(2, 300); wr(3, -5);
    i_drain_len = (AW+1)'(4); i_shift = WS'(3); i_out_ready = 1'b1; i_drain_start = 1'b1;
    tick();
    i_drain_start = 1'b0;
    beats = 0;
    for (int cyc = 0; cyc < 20 && beats < 2; cyc++) begin
      if (o_out_valid && i_out_ready) beats++;
      tick();
    end
    chk("abort_beats", longint'(beats), 2);
    chk("abort_pre_busy", longint'(o_busy), 1);
    rst = 1'b1;
    #1;
    chk("abort_out_valid", longint'(o_out_valid), 0);
    chk("abort_out_data", longint'(o_out_data), 0);
    chk("abort_out_last", longint'(o_out_last), 0);
    chk("abort_busy", longint'(o_busy), 0);
    chk("abort_done", longint'(o_drain_done), 0);
    chk("abort_psum_vld", longint'(o_psum_vld), 0);
    chk("abort_err", longint'(o_err), 0);
    tick();
    rst = 1'b0;
    done_any = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      done_any |= o_drain_done;
      tick();
    end
    chk("abort_no_done", longint'(done_any), 0);

    // A write during drain is dropped and flags the sticky error
    wr(2, 55);
    i_out_ready = 1'b0; i_drain_len = (AW+1)'(4); i_shift = '0; i_drain_start = 1'b1;
    tick();
    i_drain_start = 1'b0;
    chk("err_before", longint'(o_err), 0);
    i_psum_we = 1'b1; i_psum_addr = AW'(2); i_psum_wdata = WP'(999);
    tick();
    i_psum_we = 1'b0;
    chk("err_set", longint'(o_err), 1);
    i_out_ready = 1'b1;
    done_any = 0;
    for (int cyc = 0; cyc < 50 && !done_any; cyc++) begin
      done_any = o_drain_done;
      tick();
    end
    chk("err_drain_done", longint'(done_any), 1);
    i_out_ready = 1'b0;
    chk("err_sticky", longint'(o_err), 1);
    rd(2, 1'b0, rv);
    chk("err_ram_kept", rv, 55);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
